// File: rtl/bp_me_network_resp_inject_arb_pkg.sv
// bp_common_pkg
//   Shared definitions for the response-network injection arbiter:
//   - inject_state_e : injection FSM states (IDLE / SEND)
//   - safe_clog2     : clog2 that never returns 0, for counter widths
//   - ceil_div       : integer ceiling division, for the flit width
//   - len_offset     : bit offset of the length field in an encoded packet
//   An encoded packet is laid out as {payload, length, y_cord, x_cord},
//   with x_cord in the least significant bits.
package bp_common_pkg;

  typedef enum logic {
    e_idle = 1'b0,
    e_send = 1'b1
  } inject_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Length sits directly above the two coordinate fields.
  function automatic int len_offset(input int x_width, input int y_width);
    return x_width + y_width;
  endfunction

endpackage

// File: rtl/bp_me_network_resp_inject_arb_rr.sv
// bp_me_resp_arb_rr
//   Requester arbiter for the response injection port.
//   Configuration macro: BP_ME_RESP_INJECT_RR_EN
//     defined   -> round-robin; the search starts at a pointer that moves to
//                  winner+1 (mod num_req_p) whenever a grant is taken.
//     undefined -> fixed priority, lowest index wins, no state.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i              : per-requester valid
//   yumi_i           : the current grant is being taken this cycle
//   grant_o          : one-hot winner (zero when no requester is valid)
module bp_me_resp_arb_rr
  import bp_common_pkg::*;
#(
  parameter int num_req_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_req_p-1:0] v_i,
  input  logic                 yumi_i,
  output logic [num_req_p-1:0] grant_o
);

`ifdef BP_ME_RESP_INJECT_RR_EN

  localparam int ptr_width_lp = safe_clog2(num_req_p);

  logic [ptr_width_lp-1:0] ptr_q, ptr_d;
  logic                    found;
  int                      idx;

  // Walk the requesters starting at the pointer, wrapping once; the first
  // valid one wins. The pointer only moves when the grant is consumed.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      for (int i = 0; i < num_req_p; i++) begin
        if (!found && (i == idx) && v_i[i]) begin
          found      = 1'b1;
          grant_o[i] = 1'b1;
          ptr_d      = (i == num_req_p - 1) ? '0 : ptr_width_lp'(i + 1);
        end
      end
    end
    if (!yumi_i) ptr_d = ptr_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

`else

  logic found;
  logic unused_inputs;

  // Fixed priority needs no history, so clock/reset/advance are unused.
  assign unused_inputs = ^{clk_i, reset_n_i, yumi_i};

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && v_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/bp_me_network_resp_inject_arb.sv
// bp_me_network_resp_inject_arb
//   Shares one response-network injection link among num_req_p requesters.
//   A winning packet is captured into a flit buffer and streamed out
//   width_lp bits per flit, holding the grant until its last flit (wormhole).
//   Configuration macro: BP_ME_RESP_INJECT_RR_EN selects round-robin
//   arbitration (see bp_me_resp_arb_rr); default is fixed priority.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   req_v_i          : per-requester packet valid
//   req_packet_i     : encoded packets, requester i in slice i
//   req_yumi_o       : one-hot packet-accepted strobe (combinational)
//   link_data_o      : current flit
//   link_v_o         : flit valid
//   link_ready_i     : downstream ready
//   busy_o           : a packet is in flight
module bp_me_network_resp_inject_arb
  import bp_common_pkg::*;
#(
  // Width parameters must be set by the instantiating system.
  parameter int num_req_p          = 2,
  parameter int x_cord_width_p     = 4,
  parameter int y_cord_width_p     = 4,
  parameter int max_num_flit_p     = 4,
  parameter int max_packet_width_p = 64,
  localparam int width_lp          = ceil_div(max_packet_width_p, max_num_flit_p),
  localparam int len_width_lp      = safe_clog2(max_num_flit_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [num_req_p-1:0]                    req_v_i,
  input  logic [num_req_p*max_packet_width_p-1:0] req_packet_i,
  output logic [num_req_p-1:0]                    req_yumi_o,
  output logic [width_lp-1:0]                     link_data_o,
  output logic                                    link_v_o,
  input  logic                                    link_ready_i,
  output logic                                    busy_o
);

  localparam int len_offset_lp = len_offset(x_cord_width_p, y_cord_width_p);

  inject_state_e                 state_q, state_d;
  logic [len_width_lp-1:0]       cnt_q, cnt_d;
  logic [max_packet_width_p-1:0] buf_q, buf_d;

  logic [num_req_p-1:0]          grant;
  logic [max_packet_width_p-1:0] sel_pkt;
  logic                          last_hs;
  logic                          accept_open;
  logic                          take;

  // A new packet may be taken when idle, or on the last-flit handshake so
  // consecutive packets leave without a bubble. Reset forces no acceptance.
  assign last_hs     = (state_q == e_send) && link_ready_i && (cnt_q == '0);
  assign accept_open = reset_n_i && ((state_q == e_idle) || last_hs);
  assign take        = accept_open && (|req_v_i);
  assign req_yumi_o  = accept_open ? grant : '0;

  bp_me_resp_arb_rr #(
    .num_req_p (num_req_p)
  ) arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (req_v_i),
    .yumi_i    (take),
    .grant_o   (grant)
  );

  // Grant is one-hot, so a priority-free select is enough.
  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant[i]) sel_pkt = req_packet_i[i*max_packet_width_p +: max_packet_width_p];
    end
  end

  // The counter holds the number of flits still to send after the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (take) begin
      state_d = e_send;
      buf_d   = sel_pkt;
      cnt_d   = sel_pkt[len_offset_lp +: len_width_lp];
    end else if (last_hs) begin
      state_d = e_idle;
    end else if ((state_q == e_send) && link_ready_i) begin
      buf_d = buf_q >> width_lp;
      cnt_d = cnt_q - len_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign link_v_o    = (state_q == e_send);
  assign busy_o      = (state_q == e_send);
  assign link_data_o = buf_q[width_lp-1:0];

endmodule

// File: doc/bp_me_network_resp_inject_arb.md
BP_ME_NETWORK_RESP_INJECT_ARB -- requirements
Module: bp_me_network_resp_inject_arb

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of requesters sharing one response-network injection port.
REQ-002 SHALL have parameter x_cord_width_p, default "inv": x coordinate field width.
REQ-003 SHALL have parameter y_cord_width_p, default "inv": y coordinate field width.
REQ-004 SHALL have parameter max_num_flit_p, default "inv": maximum number of flits per packet.
REQ-005 SHALL have parameter max_packet_width_p, default "inv": width of an encoded packet {payload, length, y_cord, x_cord}.
REQ-006 SHALL derive flit width width_lp = ceil(max_packet_width_p/max_num_flit_p) and len_width_lp = BSG_SAFE_CLOG2(max_num_flit_p).
REQ-007 SHALL have port clk_i, input, width 1: the single clock.
REQ-008 SHALL have port reset_n_i, input, width 1: reset, asynchronous, active-low.
REQ-009 SHALL have port req_v_i, input, width num_req_p: per-requester packet valid.
REQ-010 SHALL have port req_packet_i, input, width num_req_p*max_packet_width_p: encoded packets, requester i at slice i.
REQ-011 SHALL have port req_yumi_o, output, width num_req_p: one-hot packet-accepted strobe.
REQ-012 SHALL have port link_data_o, output, width width_lp: current flit.
REQ-013 SHALL have port link_v_o, output, width 1: flit valid.
REQ-014 SHALL have port link_ready_i, input, width 1: downstream accepts flit when link_v_o & link_ready_i.
REQ-015 SHALL have port busy_o, output, width 1: a packet is in flight.

Function
REQ-016 SHALL implement two states: IDLE, SEND.
REQ-017 In IDLE with any req_v_i set, SHALL select one winner, assert req_yumi_o[winner] combinationally that cycle, register the packet into a flit buffer, load the flit counter with the packet's length field (bits [x+y +: len_width_lp]), and enter SEND.
REQ-018 In IDLE with no req_v_i, SHALL keep req_yumi_o=0 and stay in IDLE.
REQ-019 In SEND, SHALL drive link_v_o=1 and link_data_o = flit buffer low width_lp bits; on handshake, SHALL shift the buffer right by width_lp and decrement the counter.
REQ-020 Handshake with counter==0 is the last flit; SHALL then accept a new winner in the same cycle if any req_v_i (back-to-back, no bubble), else return to IDLE.
REQ-021 SHALL hold the grant (wormhole lock) for all length+1 flits; no other requester receives yumi mid-packet.
REQ-022 SHALL never assert req_yumi_o while SEND is not on its last-flit handshake.
REQ-023 Without handshake in SEND, SHALL hold link_data_o and counter stable.
REQ-024 busy_o SHALL equal (state==SEND).
REQ-025 Counter SHALL be len_width_lp bits; a length field of 0 denotes a single-flit packet.
REQ-026 Upper buffer bits shifted in SHALL be zero.

Reset
REQ-027 On reset_n_i low, asynchronously: state=IDLE, link_v_o=0, busy_o=0, req_yumi_o=0, counter=0, round-robin pointer=0; buffer contents don't-care.
REQ-028 Reset mid-packet SHALL abandon the packet; no partial flit reissued after release.

Configuration
REQ-029 With BP_ME_RESP_INJECT_RR_EN defined, arbitration SHALL be round-robin: pointer advances to winner+1 (mod num_req_p) on each grant, search starts at pointer.
REQ-030 Without BP_ME_RESP_INJECT_RR_EN, arbitration SHALL be fixed priority, lowest index wins; no pointer register.

Structure
REQ-031 State enum and packet field offset helpers SHALL live in bp_common_pkg; widths derived locally.
REQ-032 Arbitration SHALL be one sub-module, bp_me_resp_arb_rr, with grant-one-hot output and a yumi/advance input.

Verification (num_req_p=3, max_num_flit_p=4, 3-flit packets unless noted)
REQ-033 Reset then req_v_i=3'b000 -> link_v_o=0, req_yumi_o=0, busy_o=0 indefinitely.
REQ-034 req_v_i=3'b010 with length=2, link_ready_i=1 -> yumi[1] cycle 0; flits 0,1,2 on cycles 1-3; busy_o falls after cycle 3.
REQ-035 All three valid, RR_EN, ready=1 -> grants 0,1,2,0 in order, last flit of each adjacent to first flit of next (no bubble).
REQ-036 Same stimulus, RR_EN undefined -> requester 0 granted every packet; 1 and 2 starved.
REQ-037 link_ready_i toggled 1,0,0,1,1 mid-packet -> link_data_o stable during stalls; exactly 3 flits delivered in order; no yumi mid-packet.
REQ-038 reset_n_i low after flit 1 -> link_v_o=0 immediately; after release, fresh grant starts at flit 0.
